// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg -- shared definitions for the EX-stage multiply/divide unit.
//   muldiv_state_t : controller states (IDLE, MUL, DIV, DONE)
//   XLEN_DEF       : default operand width
//   CNT_W_DEF      : iteration counter width for the default operand width
//   DIV0_QUOT      : quotient returned on divide by zero (all ones)
package mips_muldiv_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned CNT_W_DEF = $clog2(XLEN_DEF);

    localparam logic [XLEN_DEF-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/mips_ex_muldiv_div_step.sv
// mips_div_step -- one combinational restoring-division iteration.
//   rem_in  : partial remainder (always < divisor for a nonzero divisor)
//   divisor : divisor magnitude
//   dvd_bit : next dividend bit shifted into the remainder
//   rem_out : updated partial remainder
//   q_bit   : quotient bit produced by this iteration
module mips_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dvd_bit,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // With rem_in < divisor the shifted value is below 2*divisor, so the
    // difference's top bit alone tells whether the trial subtraction fits.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {1'b0, divisor};
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule

// File: rtl/mips_ex_muldiv.sv
// mips_ex_muldiv -- multi-cycle multiply/divide unit for the EX stage.
// Operands are captured once when a request is seen in IDLE; the iterative
// datapath then runs one bit per cycle while the hazard unit stalls EX.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   ex_valid            : EX holds a valid instruction
//   ex_mul_sign         : EX instruction is MULT/MULTU (wins over divide)
//   ex_div_sign         : EX instruction is DIV/DIVU
//   ex_signed           : signed operation (MULT/DIV)
//   ex_src_a, ex_src_b  : rs / rt operands
//   ex_hi_value         : product high half / remainder
//   ex_lo_value         : product low half / quotient
//   ex_mult_complete    : one-cycle pulse, multiply result valid
//   ex_div_complete     : one-cycle pulse, divide result valid
//   muldiv_busy         : controller not idle
// Build option: MIPS_MULDIV_FAST_MUL_EN selects a single-cycle registered
// multiplier (IDLE -> DONE directly); divide is unaffected.
module mips_ex_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_mul_sign,
    input  logic            ex_div_sign,
    input  logic            ex_signed,
    input  logic [XLEN-1:0] ex_src_a,
    input  logic [XLEN-1:0] ex_src_b,
    output logic [XLEN-1:0] ex_hi_value,
    output logic [XLEN-1:0] ex_lo_value,
    output logic            ex_mult_complete,
    output logic            ex_div_complete,
    output logic            muldiv_busy
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    muldiv_state_t state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  acc_hi_q, acc_hi_d;   // product high / partial remainder
    logic [XLEN-1:0]  acc_lo_q, acc_lo_d;   // multiplier / dividend -> quotient
    logic [XLEN-1:0]  mag_b_q, mag_b_d;
    logic [XLEN-1:0]  src_a_q, src_a_d;     // raw dividend for divide by zero
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic             mult_cmp_q, mult_cmp_d;
    logic             div_cmp_q, div_cmp_d;

    logic req_mul, req_div, hold_div;
    logic a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_nx, mul_lo_nx;
    logic [2*XLEN-1:0] mul_prod, mul_res;
    logic [XLEN-1:0]   div_rem_nx, div_lo_nx;
    logic              div_q_bit;
    logic [XLEN-1:0]   div_quot, div_rem;
`ifdef MIPS_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_res;
`endif

    mips_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in  (acc_hi_q),
        .divisor (mag_b_q),
        .dvd_bit (acc_lo_q[XLEN-1]),
        .rem_out (div_rem_nx),
        .q_bit   (div_q_bit)
    );

    always_comb begin
        req_mul  = ex_valid & ex_mul_sign;
        req_div  = ex_valid & ex_div_sign & ~ex_mul_sign;
        hold_div = ex_valid & ex_div_sign;

        a_neg = ex_signed & ex_src_a[XLEN-1];
        b_neg = ex_signed & ex_src_b[XLEN-1];
        mag_a = a_neg ? -ex_src_a : ex_src_a;
        mag_b = b_neg ? -ex_src_b : ex_src_b;

        // Shift-add: the carry out of the high half shifts into the result,
        // the consumed multiplier bit shifts out of the low half.
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
        mul_hi_nx = mul_sum[XLEN:1];
        mul_lo_nx = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        mul_prod  = {mul_hi_nx, mul_lo_nx};
        mul_res   = neg_res_q ? -mul_prod : mul_prod;

        div_lo_nx = {acc_lo_q[XLEN-2:0], div_q_bit};
        div_quot  = neg_res_q ? -div_lo_nx : div_lo_nx;
        div_rem   = neg_rem_q ? -div_rem_nx : div_rem_nx;

`ifdef MIPS_MULDIV_FAST_MUL_EN
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        fast_res  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
`endif
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        mag_b_d    = mag_b_q;
        src_a_d    = src_a_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mult_cmp_d = 1'b0;
        div_cmp_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_mul) begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
                    {hi_d, lo_d} = fast_res;
                    mult_cmp_d   = 1'b1;
                    state_d      = ST_DONE;
`else
                    acc_hi_d  = '0;
                    acc_lo_d  = mag_a;
                    mag_b_d   = mag_b;
                    neg_res_d = a_neg ^ b_neg;
                    count_d   = '0;
                    state_d   = ST_MUL;
`endif
                end else if (req_div) begin
                    acc_hi_d  = '0;
                    acc_lo_d  = mag_a;
                    mag_b_d   = mag_b;
                    src_a_d   = ex_src_a;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    count_d   = '0;
                    state_d   = ST_DIV;
                end
            end
            ST_MUL: begin
                if (!req_mul) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = mul_hi_nx;
                    acc_lo_d = mul_lo_nx;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == CNT_LAST) begin
                        {hi_d, lo_d} = mul_res;
                        mult_cmp_d   = 1'b1;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DIV: begin
                if (!hold_div) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_hi_d = div_rem_nx;
                    acc_lo_d = div_lo_nx;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == CNT_LAST) begin
                        // Divide by zero still runs the full iteration count.
                        if (mag_b_q == '0) begin
                            lo_d = XLEN'(DIV0_QUOT);
                            hi_d = src_a_q;
                        end else begin
                            lo_d = div_quot;
                            hi_d = div_rem;
                        end
                        div_cmp_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            // The instruction departs on the edge ending DONE; never re-arm here.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            mag_b_q    <= '0;
            src_a_q    <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            mult_cmp_q <= 1'b0;
            div_cmp_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            mag_b_q    <= mag_b_d;
            src_a_q    <= src_a_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mult_cmp_q <= mult_cmp_d;
            div_cmp_q  <= div_cmp_d;
        end
    end

    assign ex_hi_value      = hi_q;
    assign ex_lo_value      = lo_q;
    assign ex_mult_complete = mult_cmp_q;
    assign ex_div_complete  = div_cmp_q;
    assign muldiv_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips_ex_muldiv.sv
// tb_mips_ex_muldiv -- directed self-checking bench for mips_ex_muldiv.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at the same point, so "cycle T+k" is observed k rising edges after issue.
module tb_mips_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_mul_sign = 1'b0;
    logic        ex_div_sign = 1'b0;
    logic        ex_signed = 1'b0;
    logic [31:0] ex_src_a = '0;
    logic [31:0] ex_src_b = '0;
    logic [31:0] ex_hi_value;
    logic [31:0] ex_lo_value;
    logic        ex_mult_complete;
    logic        ex_div_complete;
    logic        muldiv_busy;

    int errors = 0;
    int checks = 0;

`ifdef MIPS_MULDIV_FAST_MUL_EN
    int mul_lat = 1;
`else
    int mul_lat = 33;
`endif
    int div_lat = 33;

    mips_ex_muldiv #(.XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_mul_sign      (ex_mul_sign),
        .ex_div_sign      (ex_div_sign),
        .ex_signed        (ex_signed),
        .ex_src_a         (ex_src_a),
        .ex_src_b         (ex_src_b),
        .ex_hi_value      (ex_hi_value),
        .ex_lo_value      (ex_lo_value),
        .ex_mult_complete (ex_mult_complete),
        .ex_div_complete  (ex_div_complete),
        .muldiv_busy      (muldiv_busy)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic mul, input logic div, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
        ex_valid    = 1'b1;
        ex_mul_sign = mul;
        ex_div_sign = div;
        ex_signed   = sgn;
        ex_src_a    = a;
        ex_src_b    = b;
    endtask

    task automatic drop();
        ex_valid    = 1'b0;
        ex_mul_sign = 1'b0;
        ex_div_sign = 1'b0;
    endtask

    // Steps edges until the first complete pulse; cyc = -1 when none within bound.
    task automatic wait_done(output int cyc, output logic saw_mul, output logic saw_div);
        cyc = -1;
        saw_mul = 1'b0;
        saw_div = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            saw_mul = ex_mult_complete;
            saw_div = ex_div_complete;
            if (saw_mul || saw_div) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic retire();
        @(posedge clk); #1;
        drop();
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (ex_hi_value !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=0", ex_hi_value); end
        checks++; if (ex_lo_value !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=0", ex_lo_value); end
        checks++; if ({ex_mult_complete, ex_div_complete, muldiv_busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {ex_mult_complete, ex_div_complete, muldiv_busy}); end
        rst = 1'b0;
    endtask

    task automatic test_mult_signed();
        int c; logic m, d;
        issue(1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 32'd3);
        wait_done(c, m, d);
        checks++; if (c !== mul_lat) begin errors++; $display("FAIL mult_latency got=%0d exp=%0d", c, mul_lat); end
        checks++; if ({m, d} !== 2'b10) begin errors++; $display("FAIL mult_pulse got=%b exp=10", {m, d}); end
        checks++; if (ex_hi_value !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", ex_hi_value); end
        checks++; if (ex_lo_value !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", ex_lo_value); end
        retire();
        checks++; if (ex_mult_complete !== 1'b0) begin errors++; $display("FAIL mult_pulse_width got=%b exp=0", ex_mult_complete); end
        @(posedge clk); #1;
        checks++; if (muldiv_busy !== 1'b0) begin errors++; $display("FAIL mult_idle got=%b exp=0", muldiv_busy); end
    endtask

    task automatic test_multu();
        int c; logic m, d;
        issue(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(c, m, d);
        checks++; if (ex_hi_value !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", ex_hi_value); end
        checks++; if (ex_lo_value !== 32'h00000001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", ex_lo_value); end
        checks++; if ({m, d} !== 2'b10) begin errors++; $display("FAIL multu_no_div got=%b exp=10", {m, d}); end
        retire();
        checks++; if (ex_div_complete !== 1'b0) begin errors++; $display("FAIL multu_no_div_after got=%b exp=0", ex_div_complete); end
    endtask

    task automatic test_div();
        int c; logic m, d;
        issue(1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2);
        wait_done(c, m, d);
        checks++; if (c !== div_lat) begin errors++; $display("FAIL div_latency got=%0d exp=%0d", c, div_lat); end
        checks++; if ({m, d} !== 2'b01) begin errors++; $display("FAIL div_pulse got=%b exp=01", {m, d}); end
        checks++; if (ex_lo_value !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo got=%h exp=fffffffd", ex_lo_value); end
        checks++; if (ex_hi_value !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi got=%h exp=ffffffff", ex_hi_value); end
        retire();
        issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        wait_done(c, m, d);
        checks++; if (ex_lo_value !== 32'd14) begin errors++; $display("FAIL divu_lo got=%0d exp=14", ex_lo_value); end
        checks++; if (ex_hi_value !== 32'd2) begin errors++; $display("FAIL divu_hi got=%0d exp=2", ex_hi_value); end
        retire();
    endtask

    task automatic test_div_corner();
        int c; logic m, d;
        issue(1'b0, 1'b1, 1'b1, 32'd5, 32'd0);
        wait_done(c, m, d);
        checks++; if (c !== div_lat) begin errors++; $display("FAIL div0_latency got=%0d exp=%0d", c, div_lat); end
        checks++; if (ex_lo_value !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo got=%h exp=ffffffff", ex_lo_value); end
        checks++; if (ex_hi_value !== 32'd5) begin errors++; $display("FAIL div0_hi got=%h exp=00000005", ex_hi_value); end
        retire();
        issue(1'b0, 1'b1, 1'b0, 32'h80000007, 32'd0);
        wait_done(c, m, d);
        checks++; if ({ex_hi_value, ex_lo_value} !== {32'h80000007, 32'hFFFFFFFF}) begin errors++; $display("FAIL divu0_hilo got=%h exp=80000007ffffffff", {ex_hi_value, ex_lo_value}); end
        retire();
        issue(1'b0, 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
        wait_done(c, m, d);
        checks++; if (ex_lo_value !== 32'h80000000) begin errors++; $display("FAIL ovf_lo got=%h exp=80000000", ex_lo_value); end
        checks++; if (ex_hi_value !== 32'h0) begin errors++; $display("FAIL ovf_hi got=%h exp=00000000", ex_hi_value); end
        retire();
    endtask

    task automatic test_back_to_back();
        int c1, c2; logic m, d;
        issue(1'b1, 1'b0, 1'b0, 32'd6, 32'd7);
        wait_done(c1, m, d);
        checks++; if ({ex_hi_value, ex_lo_value} !== {32'd0, 32'd42}) begin errors++; $display("FAIL b2b_mul_hilo got=%h exp=%h", {ex_hi_value, ex_lo_value}, {32'd0, 32'd42}); end
        // Next instruction enters EX on the edge that ends DONE.
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        checks++; if (ex_mult_complete !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width got=%b exp=0", ex_mult_complete); end
        wait_done(c2, m, d);
        checks++; if (c2 + 1 !== 34) begin errors++; $display("FAIL b2b_gap got=%0d exp=34", c2 + 1); end
        checks++; if ({m, d, ex_hi_value, ex_lo_value} !== {2'b01, 32'd2, 32'd14}) begin errors++; $display("FAIL b2b_div got=%b/%h/%h exp=01/2/14", {m, d}, ex_hi_value, ex_lo_value); end
        retire();
        @(posedge clk); #1;
        checks++; if (muldiv_busy !== 1'b0) begin errors++; $display("FAIL b2b_no_restart got=%b exp=0", muldiv_busy); end
    endtask

    task automatic test_abort();
        int pulses = 0;
        issue(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        drop();
        @(posedge clk); #1;
        checks++; if (muldiv_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", muldiv_busy); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ex_mult_complete || ex_div_complete) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_pulse got=%0d exp=0", pulses); end
        checks++; if ({ex_hi_value, ex_lo_value} !== {32'd2, 32'd14}) begin errors++; $display("FAIL abort_hold got=%h exp=%h", {ex_hi_value, ex_lo_value}, {32'd2, 32'd14}); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 1'b0, 32'd6, 32'd7);
`ifndef MIPS_MULDIV_FAST_MUL_EN
        repeat (5) @(posedge clk);
        #1;
        checks++; if (muldiv_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got=%b exp=1", muldiv_busy); end
`endif
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({ex_hi_value, ex_lo_value} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo got=%h exp=0", {ex_hi_value, ex_lo_value}); end
        checks++; if ({ex_mult_complete, ex_div_complete, muldiv_busy} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got=%b exp=000", {ex_mult_complete, ex_div_complete, muldiv_busy}); end
        drop();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (muldiv_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b exp=0", muldiv_busy); end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu();
        test_div();
        test_div_corner();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_ex_muldiv.md
Name: mips_ex_muldiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage. It produces HI/LO results and the one-cycle `ex_mult_complete` / `ex_div_complete` pulses.
- The hazard/forwarding unit consumes these pulses to release its `hd_wait` stall and to forward HI/LO.
- Covers MULT/MULTU and DIV/DIVU. Operands are sampled once at start; the iterative datapath runs while EX is stalled.

Parameters:
- XLEN, 32, operand width; HI/LO are XLEN each; iteration count = XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_mul_sign  in  1  EX instruction is MULT/MULTU (ex_op[17]).
- ex_div_sign  in  1  EX instruction is DIV/DIVU (ex_op[16]).
- ex_signed  in  1  1 = signed (MULT/DIV), 0 = unsigned.
- ex_src_a  in  XLEN  rs operand (multiplicand / dividend).
- ex_src_b  in  XLEN  rt operand (multiplier / divisor).
- ex_hi_value  out  XLEN  HI result (product high half / remainder).
- ex_lo_value  out  XLEN  LO result (product low half / quotient).
- ex_mult_complete  out  1  one-cycle pulse: multiply result valid.
- ex_div_complete  out  1  one-cycle pulse: divide result valid.
- muldiv_busy  out  1  state != IDLE.

Behaviour:
- Reset: state = IDLE, count = 0, ex_hi_value = ex_lo_value = 0, both complete flags = 0, muldiv_busy = 0.
- Request: req_mul = ex_valid & ex_mul_sign; req_div = ex_valid & ex_div_sign & !ex_mul_sign (multiply wins if both are set).
- Request handshake is level-based. The hazard unit holds EX stable until the complete pulse. The instruction leaves EX on the edge that ends the DONE cycle.
- States and transitions:
  - IDLE: on req, latch |a|, |b| (magnitudes if ex_signed, else raw), result-sign flags, and op type; count = 0. Go to MUL or DIV.
  - MUL: radix-2 shift-add on magnitudes, one bit per cycle, XLEN cycles. At count == XLEN-1 go to DONE.
  - DIV: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles. At count == XLEN-1 go to DONE.
  - DONE: drive the complete flag matching op type, high for exactly this cycle. Registered HI/LO (sign-corrected) are valid this cycle. Next state is IDLE.
- Latency: request first seen in IDLE at cycle T → iterations T+1..T+XLEN → DONE at T+XLEN+1. That is 34 cycles total for XLEN=32.
- Back-to-back: a new request in the cycle after DONE is accepted normally. The DONE→IDLE cycle does not re-trigger on the departed instruction.
- Sign correction:
  - Product is negated if sign(a) != sign(b).
  - Quotient is negated if signs differ; remainder takes the sign of the dividend.
- Divide by zero: lo = all-ones, hi = ex_src_a (original, unmodified), for both signed and unsigned. It still takes the full XLEN-cycle latency.
- Signed overflow, 0x80000000 / -1: lo = 0x80000000, hi = 0.
- Abort: if ex_valid drops (or the op bit for the running type drops) in MUL/DIV, return to IDLE next cycle. No complete pulse; HI/LO are unchanged.
- HI/LO outputs hold the last completed result until the next DONE updates them.
- Reset mid-operation: immediate return to the reset values; no pulse.

Optional Feature:
- MIPS_MULDIV_FAST_MUL_EN
- Defined: multiply is computed by a single registered full-width multiplier. IDLE→DONE directly, so complete is at T+1 and the MUL state is unused. Divide is unchanged.
- Undefined: iterative multiply as specified above.

Decomposition:
- Package mips_muldiv_pkg holds:
  - state encoding (IDLE, MUL, DIV, DONE);
  - XLEN default;
  - DIV0 quotient constant (all-ones);
  - count width = clog2(XLEN).
- Sub-module mips_div_step: combinational single restoring-division iteration. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder, quotient bit.

Test Plan:
- MULT signed 0xFFFFFFFE (-2) × 3 → ex_mult_complete pulse at cycle T+33, hi=0xFFFFFFFF, lo=0xFFFFFFFA; pulse lasts exactly 1 cycle.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; ex_div_complete stays 0 throughout.
- DIV signed -7 / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 7 → lo=14, hi=2.
- DIV 5 / 0 → lo=0xFFFFFFFF, hi=5 at T+33. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Back-to-back MULT then DIV held per hazard stall → two pulses 34 cycles apart with no extra start; ex_valid dropped at T+10 of a DIV → no pulse, HI/LO keep prior values, muldiv_busy=0 by T+11.
- Assert rst mid-MUL at T+5 → outputs 0 asynchronously, state IDLE. With MIPS_MULDIV_FAST_MUL_EN defined: MULT 6×7 → pulse at T+1, lo=42, hi=0.
